dmem_responder: RTL

- Memory-mapped data-memory responder sitting on the processor's load/store port.
- The processor core is the initiator; this block answers its load and store requests over a req/ready handshake.
- Wait-state latency is programmable, so the core's stall logic can be exercised under non-ideal memory timing.
- Word-organised storage with byte-lane steering for byte/half/word accesses, plus sign/zero extension on loads.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_lane_align.sv | 68 ++++++
 rtl/dmem_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module  : dmem_pkg
// Purpose : Shared types and helpers for the data-memory responder.
//           Access-size encoding, responder FSM states, wait-counter width,
//           and a helper that derives the word-index width from the depth.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  // Access size as presented on size_i; 2'b11 behaves as a word access.
  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Wide enough for the largest wait-state setting (15).
  localparam int unsigned WAIT_CNT_W = 4;

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module  : dmem_lane_align
// Purpose : Combinational byte-lane steering for the data-memory responder.
//           Store side: byte enables and lane-replicated write data.
//           Load side : lane extraction plus sign/zero extension.
// Ports   : i_size      access size
//           i_addr_lo   byte address bits [1:0]
//           i_wdata     right-aligned store data
//           i_unsigned  1 = zero-extend loads
//           i_rword     stored word at the addressed index
//           o_be        per-lane write enables
//           o_wdata     write data replicated onto every lane
//           o_rdata     extracted and extended load data
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic        i_unsigned,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Shift the addressed lane down to bit 0; half accesses ignore addr[0].
  assign w_byte_sh = i_rword >> {i_addr_lo, 3'b000};
  assign w_half_sh = i_rword >> {i_addr_lo[1], 4'b0000};
  assign w_byte    = w_byte_sh[7:0];
  assign w_half    = w_half_sh[15:0];

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rword;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        // Replicating the byte means the enables alone select the lane.
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = i_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module  : dmem_responder
// Purpose : Data-memory responder on the core's load/store port with a
//           programmable number of wait states, byte/half/word lane steering
//           and sign/zero extension of loads.
// Config  : DMEM_MISALIGN_ERR_EN - when defined, misaligned and out-of-range
//           accesses report err_o and misaligned stores are dropped; when
//           undefined, misaligned accesses are aligned down and err_o is 0.
// Ports   : clk         rising-edge clock
//           rst         asynchronous active-low reset
//           req_i       request, held until ready_o
//           we_i        1 = store, 0 = load
//           addr_i      byte address
//           wdata_i     right-aligned store data
//           size_i      00 byte, 01 half, 10/11 word
//           unsigned_i  1 = zero-extend loads
//           ready_o     one-cycle completion pulse
//           rdata_o     load result, valid with ready_o
//           err_o       access error, qualified by ready_o
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic              ready_o,
  output logic [31:0]       rdata_o,
  output logic              err_o
);

  localparam int unsigned c_IDX_W = idx_width(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] c_WAIT_INIT =
    (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

  state_e                r_state;
  state_e                w_next;
  logic [WAIT_CNT_W-1:0] r_cnt;

  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [31:0]           r_wdata;
  size_e                 r_size;
  logic                  r_uns;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic [31:0]           r_mem [DEPTH_WORDS];

  logic                  w_we;
  logic [ADDR_W-1:0]     w_addr;
  logic [31:0]           w_wdata;
  size_e                 w_size;
  logic                  w_uns;
  logic [c_IDX_W-1:0]    w_idx;
  logic                  w_oor;
  logic                  w_bad;
  logic                  w_err;
  logic                  w_commit;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_sh;
  logic [31:0]           w_ld_data;
  logic [31:0]           w_rword;

  // With zero wait states the commit edge is the acceptance edge, so the
  // live inputs are used in IDLE and the captured request everywhere else.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_we    = we_i;
      w_addr  = addr_i;
      w_wdata = wdata_i;
      w_size  = size_e'(size_i);
      w_uns   = unsigned_i;
    end else begin
      w_we    = r_we;
      w_addr  = r_addr;
      w_wdata = r_wdata;
      w_size  = r_size;
      w_uns   = r_uns;
    end
  end

  assign w_idx   = w_addr[c_IDX_W+1:2];
  assign w_oor   = (w_addr >> (c_IDX_W + 2)) != '0;
  assign w_rword = r_mem[w_idx];

`ifdef DMEM_MISALIGN_ERR_EN
  logic w_misalign;
  always_comb begin
    w_misalign = 1'b0;
    case (w_size)
      SZ_BYTE: w_misalign = 1'b0;
      SZ_HALF: w_misalign = w_addr[0];
      default: w_misalign = (w_addr[1:0] != 2'b00);
    endcase
  end
  assign w_bad = w_oor | w_misalign;
  assign w_err = w_bad;
`else
  assign w_bad = w_oor;
  assign w_err = 1'b0;
`endif

  // True on the clock edge that moves the FSM into RESP.
  assign w_commit = ((r_state == ST_IDLE) && req_i && (WAIT_STATES == 0)) ||
                    ((r_state == ST_WAIT) && (r_cnt == '0));

  dmem_lane_align u_lane_align (
    .i_size     (w_size),
    .i_addr_lo  (w_addr[1:0]),
    .i_wdata    (w_wdata),
    .i_unsigned (w_uns),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_wdata_sh),
    .o_rdata    (w_ld_data)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req_i) w_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && req_i) begin
        r_we    <= we_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
        r_size  <= size_e'(size_i);
        r_uns   <= unsigned_i;
        r_cnt   <= c_WAIT_INIT;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit) begin
        r_err <= w_err;
        if (w_err) begin
          r_rdata <= '0;
        end else if (!w_we) begin
          r_rdata <= w_bad ? 32'h0 : w_ld_data;
        end
      end
    end
  end

  // Storage is never reset; the rst qualifier keeps a write from landing on
  // an edge that coincides with an asserted reset.
  always_ff @(posedge clk) begin
    if (rst && w_commit && w_we && !w_bad) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  assign ready_o = (r_state == ST_RESP);
  assign err_o   = ready_o & r_err;
  assign rdata_o = r_rdata;

endmodule

`default_nettype wire
